// File: rtl/pong_field.sv
// Pong game-field engine: paddles, ball physics, BCD scoring and the serve/point/over
// sequencing, plus a zero-latency paddle/ball renderer for the current pixel.
module pong_field #(
  parameter int          H_RES       = 640,
  parameter int          V_RES       = 480,
  parameter int          BALL_SIZE   = 8,
  parameter int          BALL_V      = 3,
  parameter int          PAD_LEN     = 108,
  parameter int          PAD_W       = 6,
  parameter int          PAD_V       = 4,
  parameter int          LEFT_PAD_X  = 40,
  parameter int          RIGHT_PAD_X = 600,
  parameter int          WIN_SCORE   = 9,
  parameter int          HOLD_FRAMES = 60,
  parameter logic [2:0]  PAD_RGB     = 3'b101,
  parameter logic [2:0]  BALL_RGB    = 3'b100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [1:0] btn_l,
  input  logic [1:0] btn_r,
  input  logic       serve,
  output logic       graph_on,
  output logic [2:0] graph_rgb,
  output logic [7:0] left_score,
  output logic [7:0] right_score,
  output logic       hit_left,
  output logic       hit_right,
  output logic       miss_left,
  output logic       miss_right,
  output logic [1:0] game_state,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_PLAY = 2'b01, ST_POINT = 2'b10, ST_OVER = 2'b11} state_t;

  localparam logic [10:0] HR = 11'(H_RES);
  localparam logic [10:0] VR = 11'(V_RES);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] BV = 11'(BALL_V);
  localparam logic [10:0] PL = 11'(PAD_LEN);
  localparam logic [10:0] PW = 11'(PAD_W);
  localparam logic [10:0] PV = 11'(PAD_V);
  localparam logic [10:0] LX = 11'(LEFT_PAD_X);
  localparam logic [10:0] RX = 11'(RIGHT_PAD_X);
  localparam logic [9:0]  BX_C  = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  BY_C  = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  PAD_C = 10'((V_RES - PAD_LEN) / 2);
  localparam logic [7:0]  WIN_BCD = 8'((WIN_SCORE / 10) * 16 + (WIN_SCORE % 10));
  localparam int          CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

  state_t        state;
  logic [9:0]    bx, by, pl_top, pr_top;
  logic          dx_neg, dy_neg, right_scored;
  logic [CW-1:0] hold_cnt;

  logic [10:0] bx_e, by_e, pl_e, pr_e, x_e, y_e;
  logic [9:0]  bx_nxt, by_nxt;
  logic        dx_nxt, dy_nxt, ov_l, ov_r;
  logic        hit_l_c, hit_r_c, miss_l_c, miss_r_c;
  logic        tick, pad_on, ball_on;

  assign bx_e = {1'b0, bx};
  assign by_e = {1'b0, by};
  assign pl_e = {1'b0, pl_top};
  assign pr_e = {1'b0, pr_top};
  assign x_e  = {1'b0, pix_x};
  assign y_e  = {1'b0, pix_y};
  assign tick = (pix_y == 10'(V_RES + 1)) && (pix_x == 10'd0);
  assign game_state = state;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [9:0] pad_next(input logic [9:0] top, input logic [1:0] btn);
    logic [10:0] t;
    t = {1'b0, top};
    if (btn == 2'b01 && t >= PV)           return top - 10'(PAD_V);
    if (btn == 2'b10 && t + PL + PV <= VR) return top + 10'(PAD_V);
    return top;
  endfunction

  // Ball motion for one PLAY frame; the two axes are resolved independently.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    by_nxt = by;  dy_nxt = dy_neg;
    bx_nxt = bx;  dx_nxt = dx_neg;
    hit_l_c = 1'b0; hit_r_c = 1'b0; miss_l_c = 1'b0; miss_r_c = 1'b0;
    ov_l = (by_e + BS > pl_e) && (by_e < pl_e + PL);
    ov_r = (by_e + BS > pr_e) && (by_e < pr_e + PL);

    if (dy_neg) begin
      if (by_e < BV) begin by_nxt = 10'd0; dy_nxt = 1'b0; end
      else by_nxt = by - 10'(BALL_V);
    end else if (by_e + BS + BV > VR) begin
      by_nxt = 10'(V_RES - BALL_SIZE); dy_nxt = 1'b1;
    end else by_nxt = by + 10'(BALL_V);

    if (dx_neg) begin
      if (bx_e >= LX + PW && bx_e < LX + PW + BV && ov_l) begin
        bx_nxt = 10'(LEFT_PAD_X + PAD_W); dx_nxt = 1'b0; hit_l_c = 1'b1;
      end else if (bx_e < BV) begin
        bx_nxt = 10'd0; miss_l_c = 1'b1;
      end else bx_nxt = bx - 10'(BALL_V);
    end else begin
      if (bx_e + BS <= RX && bx_e + BS + BV > RX && ov_r) begin
        bx_nxt = 10'(RIGHT_PAD_X - BALL_SIZE); dx_nxt = 1'b1; hit_r_c = 1'b1;
      end else if (bx_e + BS + BV > HR) begin
        bx_nxt = 10'(H_RES - BALL_SIZE); miss_r_c = 1'b1;
      end else bx_nxt = bx + 10'(BALL_V);
    end
  end

  // NOTE: all state is registered with non-blocking assignments; reset is synchronous and overrides tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      bx <= BX_C; by <= BY_C; pl_top <= PAD_C; pr_top <= PAD_C;
      dx_neg <= 1'b0; dy_neg <= 1'b0; right_scored <= 1'b0;
      hold_cnt <= '0; left_score <= 8'h00; right_score <= 8'h00; winner <= 2'b00;
      hit_left <= 1'b0; hit_right <= 1'b0; miss_left <= 1'b0; miss_right <= 1'b0;
    end else begin
      hit_left <= 1'b0; hit_right <= 1'b0; miss_left <= 1'b0; miss_right <= 1'b0;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            pl_top <= PAD_C; pr_top <= PAD_C;
            if (serve) begin state <= ST_PLAY; dx_neg <= 1'b0; dy_neg <= 1'b0; end
          end
          ST_PLAY: begin
            pl_top <= pad_next(pl_top, btn_l);
            pr_top <= pad_next(pr_top, btn_r);
            bx <= bx_nxt; by <= by_nxt; dx_neg <= dx_nxt; dy_neg <= dy_nxt;
            hit_left <= hit_l_c; hit_right <= hit_r_c;
            miss_left <= miss_l_c; miss_right <= miss_r_c;
            if (miss_l_c || miss_r_c) begin
              state <= ST_POINT; hold_cnt <= '0; right_scored <= miss_l_c;
              if (miss_l_c) right_score <= bcd_inc(right_score);
              else          left_score  <= bcd_inc(left_score);
            end
          end
          ST_POINT: begin
            pl_top <= pad_next(pl_top, btn_l);
            pr_top <= pad_next(pr_top, btn_r);
            if (hold_cnt == HOLD_LAST) begin
              bx <= BX_C; by <= BY_C; hold_cnt <= '0;
              if ((right_scored ? right_score : left_score) == WIN_BCD) begin
                state <= ST_OVER; winner <= right_scored ? 2'b10 : 2'b01;
              end else begin
                // Serve toward the player who just conceded.
                state <= ST_PLAY; dx_neg <= right_scored; dy_neg <= 1'b0;
              end
            end else hold_cnt <= hold_cnt + 1'b1;
          end
          ST_OVER: begin
            pl_top <= PAD_C; pr_top <= PAD_C;
            if (serve) begin
              state <= ST_IDLE; left_score <= 8'h00; right_score <= 8'h00; winner <= 2'b00;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Renderer: combinational on registered positions, paddles drawn over the ball.
  always_comb begin
    pad_on  = ((x_e >= LX && x_e < LX + PW) && (y_e >= pl_e && y_e < pl_e + PL)) ||
              ((x_e >= RX && x_e < RX + PW) && (y_e >= pr_e && y_e < pr_e + PL));
    ball_on = (x_e >= bx_e && x_e < bx_e + BS) && (y_e >= by_e && y_e < by_e + BS);
    graph_on  = pad_on || ball_on;
    graph_rgb = pad_on ? PAD_RGB : (ball_on ? BALL_RGB : 3'b000);
  end

endmodule

// File: tb/tb_pong_field.sv
// Randomised bench for pong_field: drives frame ticks directly and compares scores,
// state, event pulses and rendered pixels against an integer model of the game rules.
module tb_pong_field;
  localparam int H_RES = 640, V_RES = 480, BS = 8, BV = 3, PL = 108, PW = 6, PV = 4;
  localparam int LPX = 40, RPX = 600, WIN = 12, HOLD = 60;
  localparam int N_TICKS = 9000;
  localparam int S_IDLE = 0, S_PLAY = 1, S_POINT = 2, S_OVER = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pix_x, pix_y;
  logic [1:0] btn_l, btn_r;
  logic       serve;
  logic       graph_on;
  logic [2:0] graph_rgb;
  logic [7:0] left_score, right_score;
  logic       hit_left, hit_right, miss_left, miss_right;
  logic [1:0] game_state, winner;

  pong_field #(
    .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(BS), .BALL_V(BV), .PAD_LEN(PL), .PAD_W(PW),
    .PAD_V(PV), .LEFT_PAD_X(LPX), .RIGHT_PAD_X(RPX), .WIN_SCORE(WIN), .HOLD_FRAMES(HOLD),
    .PAD_RGB(3'b101), .BALL_RGB(3'b100)
  ) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .btn_l(btn_l), .btn_r(btn_r),
    .serve(serve), .graph_on(graph_on), .graph_rgb(graph_rgb), .left_score(left_score),
    .right_score(right_score), .hit_left(hit_left), .hit_right(hit_right),
    .miss_left(miss_left), .miss_right(miss_right), .game_state(game_state), .winner(winner)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference game model (plain integers, scores kept in decimal)
  int m_state, m_bx, m_by, m_pl, m_pr, m_ls, m_rs, m_win, m_cnt;
  bit m_dxn, m_dyn, m_right_scored, m_hl, m_hr, m_ml, m_mr;

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int pad_move(input int top, input logic [1:0] b);
    if (b == 2'b01 && top >= PV) return top - PV;
    if (b == 2'b10 && top + PL + PV <= V_RES) return top + PV;
    return top;
  endfunction

  task automatic centre_ball();
    m_bx = (H_RES - BS) / 2;
    m_by = (V_RES - BS) / 2;
  endtask

  task automatic model_reset();
    m_state = S_IDLE; centre_ball();
    m_pl = (V_RES - PL) / 2; m_pr = m_pl;
    m_dxn = 0; m_dyn = 0; m_right_scored = 0;
    m_ls = 0; m_rs = 0; m_win = 0; m_cnt = 0;
    m_hl = 0; m_hr = 0; m_ml = 0; m_mr = 0;
  endtask

  task automatic model_tick(input bit srv, input logic [1:0] bl, input logic [1:0] br);
    int obx, oby, opl, opr;
    bit ovl, ovr;
    obx = m_bx; oby = m_by; opl = m_pl; opr = m_pr;
    m_hl = 0; m_hr = 0; m_ml = 0; m_mr = 0;
    if (m_state == S_PLAY || m_state == S_POINT) begin
      m_pl = pad_move(opl, bl);
      m_pr = pad_move(opr, br);
    end else begin
      m_pl = (V_RES - PL) / 2; m_pr = m_pl;
    end
    case (m_state)
      S_IDLE: if (srv) begin m_state = S_PLAY; m_dxn = 0; m_dyn = 0; end
      S_PLAY: begin
        if (m_dyn) begin
          if (oby < BV) begin m_by = 0; m_dyn = 0; end else m_by = oby - BV;
        end else if (oby + BS + BV > V_RES) begin
          m_by = V_RES - BS; m_dyn = 1;
        end else m_by = oby + BV;
        ovl = (oby + BS > opl) && (oby < opl + PL);
        ovr = (oby + BS > opr) && (oby < opr + PL);
        if (m_dxn) begin
          if (obx >= LPX + PW && obx - BV < LPX + PW && ovl) begin
            m_bx = LPX + PW; m_dxn = 0; m_hl = 1;
          end else if (obx < BV) begin
            m_bx = 0; m_ml = 1; m_rs++; m_state = S_POINT; m_cnt = 0; m_right_scored = 1;
          end else m_bx = obx - BV;
        end else begin
          if (obx + BS <= RPX && obx + BS + BV > RPX && ovr) begin
            m_bx = RPX - BS; m_dxn = 1; m_hr = 1;
          end else if (obx + BS + BV > H_RES) begin
            m_bx = H_RES - BS; m_mr = 1; m_ls++; m_state = S_POINT; m_cnt = 0; m_right_scored = 0;
          end else m_bx = obx + BV;
        end
      end
      S_POINT: begin
        m_cnt++;
        if (m_cnt == HOLD) begin
          centre_ball();
          if ((m_right_scored ? m_rs : m_ls) == WIN) begin
            m_state = S_OVER; m_win = m_right_scored ? 2 : 1;
          end else begin
            m_state = S_PLAY; m_dxn = m_right_scored; m_dyn = 0;
          end
        end
      end
      default: if (srv) begin m_state = S_IDLE; m_ls = 0; m_rs = 0; m_win = 0; end
    endcase
  endtask

  function automatic logic [3:0] exp_pixel(input int x, input int y);
    bit pad, ball;
    pad  = (x >= LPX && x < LPX + PW && y >= m_pl && y < m_pl + PL) ||
           (x >= RPX && x < RPX + PW && y >= m_pr && y < m_pr + PL);
    ball = (x >= m_bx && x < m_bx + BS && y >= m_by && y < m_by + BS);
    if (pad)  return 4'b1101;
    if (ball) return 4'b1100;
    return 4'b0000;
  endfunction

  task automatic check_status();
    check("game_state", 32'(game_state), 32'(m_state));
    check("left_score", 32'(left_score), 32'(bcd(m_ls)));
    check("right_score", 32'(right_score), 32'(bcd(m_rs)));
    check("winner", 32'(winner), 32'(m_win));
    check("pulses", 32'({hit_left, hit_right, miss_left, miss_right}), 32'({m_hl, m_hr, m_ml, m_mr}));
  endtask

  task automatic check_pixel(input int x, input int y);
    @(negedge clk);
    pix_x = 10'(x); pix_y = 10'(y);
    #1;
    check("pixel", 32'({graph_on, graph_rgb}), 32'(exp_pixel(x, y)));
  endtask

  task automatic random_pixel();
    int x, y;
    case ($urandom_range(4))
      0: begin x = m_bx; y = m_by; end
      1: begin x = m_bx + BS - 1; y = m_by + BS - 1; end
      2: begin x = m_bx + BS; y = m_by + int'($urandom_range(BS - 1)); end
      3: begin
        if ($urandom_range(1) == 1) begin x = LPX + PW - 1; y = m_pl + PL - int'($urandom_range(1)); end
        else begin x = RPX; y = m_pr + PL - int'($urandom_range(1)); end
      end
      default: begin x = int'($urandom_range(H_RES - 1)); y = int'($urandom_range(V_RES - 1)); end
    endcase
    check_pixel(x, y);
  endtask

  initial begin
    logic [1:0] bl, br;
    bit srv, rst_now;
    reset = 1'b1; serve = 1'b0; btn_l = 2'b00; btn_r = 2'b00;
    pix_x = 10'd100; pix_y = 10'd100;
    bl = 2'b00; br = 2'b00;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_status();
    check_pixel(316, 236);
    check_pixel(323, 243);
    check_pixel(324, 236);
    check_pixel(LPX, 186);
    check_pixel(RPX + PW - 1, 186 + PL - 1);
    check_pixel(RPX + PW, 200);

    for (int n = 0; n < N_TICKS; n++) begin
      if ($urandom_range(15) == 0) bl = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) br = 2'($urandom_range(3));
      srv = ($urandom_range(3) == 0);
      rst_now = (n == 400);
      @(negedge clk);
      pix_x = 10'd0; pix_y = 10'(V_RES + 1);
      serve = srv; btn_l = bl; btn_r = br; reset = rst_now;
      @(posedge clk);
      if (rst_now) model_reset();
      else model_tick(srv, bl, br);
      @(negedge clk);
      reset = 1'b0; serve = 1'b0;
      pix_x = 10'(int'($urandom_range(H_RES - 1))); pix_y = 10'd0;
      check_status();
      @(negedge clk);
      check("pulse_clear", 32'({hit_left, hit_right, miss_left, miss_right}), 32'd0);
      repeat (3) random_pixel();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
